// File: rtl/sf_camera_mem_writer.sv
// Camera FIFO to memory writer: drains ping-pong FIFO blocks into linear single-beat memory writes.
// Optional feature macro: SF_CAMERA_MEM_WRITER_BYTE_SWAP_EN (byte-reverse each dword before writing).
module sf_camera_mem_writer #(
  parameter logic [31:0] ADDR_INC = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic [31:0] i_base_addr,
  input  logic [23:0] i_frame_dwords,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic [23:0] o_dword_count,
  input  logic        i_rfifo_ready,
  output logic        o_rfifo_activate,
  output logic        o_rfifo_strobe,
  input  logic [31:0] i_rfifo_data,
  input  logic [23:0] i_rfifo_size,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_data,
  input  logic        i_mem_ack
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACTIVATE = 3'd1,
    ST_FETCH    = 3'd2,
    ST_WRITE    = 3'd3,
    ST_ACK_WAIT = 3'd4,
    ST_RELEASE  = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

`ifdef SF_CAMERA_MEM_WRITER_BYTE_SWAP_EN
  // First captured pixel byte ends up in the MSB.
  function automatic logic [31:0] swap_bytes(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction
`endif

  state_t      state_r, state_s;
  logic [31:0] addr_r, addr_fsm_s, addr_s;
  logic [23:0] block_size_r, block_size_s;
  logic [23:0] block_cnt_r, block_cnt_s;
  logic [23:0] dword_fsm_s, dword_s;
  logic        frame_end_r, frame_end_s;
  logic        enable_d_r;
  logic        enable_rise_s;
  logic        block_last_s;
  logic        frame_hit_s;
  logic [31:0] wr_data_s;
  logic        busy_s;
  logic        frame_done_s;
  logic        activate_s;
  logic        strobe_s;
  logic        mem_we_s;
  logic [31:0] mem_addr_s;
  logic [31:0] mem_data_s;

`ifdef SF_CAMERA_MEM_WRITER_BYTE_SWAP_EN
  assign wr_data_s = swap_bytes(i_rfifo_data);
`else
  assign wr_data_s = i_rfifo_data;
`endif

  assign enable_rise_s = i_enable & ~enable_d_r;
  assign block_last_s  = (block_cnt_r + 24'd1) == block_size_r;
  assign frame_hit_s   = (i_frame_dwords != 24'd0) && ((o_dword_count + 24'd1) == i_frame_dwords);

  // An enable rising edge restarts the frame, overriding FSM address/count updates.
  assign addr_s  = enable_rise_s ? i_base_addr : addr_fsm_s;
  assign dword_s = enable_rise_s ? 24'd0 : dword_fsm_s;
  assign busy_s  = (state_s != ST_IDLE);

  // Next-state and registered-output computation.
  always_comb begin
    state_s      = state_r;
    addr_fsm_s   = addr_r;
    block_size_s = block_size_r;
    block_cnt_s  = block_cnt_r;
    dword_fsm_s  = o_dword_count;
    frame_end_s  = frame_end_r;
    frame_done_s = 1'b0;
    activate_s   = o_rfifo_activate;
    strobe_s     = 1'b0;
    mem_we_s     = o_mem_we;
    mem_addr_s   = o_mem_addr;
    mem_data_s   = o_mem_data;
    case (state_r)
      ST_IDLE: begin
        if (i_enable && i_rfifo_ready) begin
          state_s = ST_ACTIVATE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACTIVATE: begin
        activate_s   = 1'b1;
        block_size_s = i_rfifo_size;
        block_cnt_s  = 24'd0;
        frame_end_s  = 1'b0;
        if (i_rfifo_size == 24'd0) begin
          state_s = ST_RELEASE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_s = ST_WRITE;
      end
      ST_WRITE: begin
        mem_we_s   = 1'b1;
        mem_addr_s = addr_r;
        mem_data_s = wr_data_s;
        state_s    = ST_ACK_WAIT;
      end
      ST_ACK_WAIT: begin
        if (i_mem_ack) begin
          mem_we_s    = 1'b0;
          strobe_s    = 1'b1;
          addr_fsm_s  = addr_r + ADDR_INC;
          block_cnt_s = block_cnt_r + 24'd1;
          dword_fsm_s = o_dword_count + 24'd1;
          frame_end_s = frame_hit_s;
          if (block_last_s || frame_hit_s || !i_enable) begin
            state_s = ST_RELEASE;
          end else begin
            state_s = ST_FETCH;
          end
        end else begin
          state_s = ST_ACK_WAIT;
        end
      end
      ST_RELEASE: begin
        activate_s = 1'b0;
        if (frame_end_r) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DONE: begin
        frame_done_s = 1'b1;
        dword_fsm_s  = 24'd0;
        addr_fsm_s   = i_base_addr;
        state_s      = ST_IDLE;
      end
      default: begin
        state_s    = ST_IDLE;
        activate_s = 1'b0;
        mem_we_s   = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      addr_r           <= 32'd0;
      block_size_r     <= 24'd0;
      block_cnt_r      <= 24'd0;
      frame_end_r      <= 1'b0;
      enable_d_r       <= 1'b0;
      o_busy           <= 1'b0;
      o_frame_done     <= 1'b0;
      o_dword_count    <= 24'd0;
      o_rfifo_activate <= 1'b0;
      o_rfifo_strobe   <= 1'b0;
      o_mem_we         <= 1'b0;
      o_mem_addr       <= 32'd0;
      o_mem_data       <= 32'd0;
    end else begin
      state_r          <= state_s;
      addr_r           <= addr_s;
      block_size_r     <= block_size_s;
      block_cnt_r      <= block_cnt_s;
      frame_end_r      <= frame_end_s;
      enable_d_r       <= i_enable;
      o_busy           <= busy_s;
      o_frame_done     <= frame_done_s;
      o_dword_count    <= dword_s;
      o_rfifo_activate <= activate_s;
      o_rfifo_strobe   <= strobe_s;
      o_mem_we         <= mem_we_s;
      o_mem_addr       <= mem_addr_s;
      o_mem_data       <= mem_data_s;
    end
  end

endmodule
